// File: rtl/dot_matrix_scanner_if.sv
// Signal bundle between the glyph scanner and its environment: control inputs, ROM read port
// and LED matrix drive.
interface dot_matrix_scanner_if;
  logic        i_en;
  logic        i_hold;
  logic [15:0] i_rom_row;
  logic [5:0]  o_rom_addr;
  logic [15:0] o_row_sel;
  logic [15:0] o_col;
  logic [1:0]  o_char_idx;
  logic        o_frame_tick;

  modport master (
    output i_en, i_hold, i_rom_row,
    input  o_rom_addr, o_row_sel, o_col, o_char_idx, o_frame_tick
  );

  modport slave (
    input  i_en, i_hold, i_rom_row,
    output o_rom_addr, o_row_sel, o_col, o_char_idx, o_frame_tick
  );
endinterface

// File: rtl/dot_matrix_scanner.sv
// Row-multiplexed 16x16 LED matrix scanner reading glyph rows from a combinational ROM and
// cycling through NUM_CHARS glyphs, each held for FRAMES_PER_CHAR frames.
module dot_matrix_scanner #(
  parameter int unsigned ROW_DWELL       = 1000,
  parameter int unsigned BLANK_CYCLES    = 2,
  parameter int unsigned FRAMES_PER_CHAR = 50,
  parameter int unsigned NUM_CHARS       = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  dot_matrix_scanner_if.slave  bus
);

  localparam int unsigned DwW = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
  localparam int unsigned BlW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int unsigned FcW = (FRAMES_PER_CHAR > 1) ? $clog2(FRAMES_PER_CHAR) : 1;

  typedef enum logic [2:0] {StIdle, StFetch, StLatch, StShow, StBlank} state_e;

  state_e         state_q;
  logic [3:0]     row_q;
  logic [FcW-1:0] frame_q;
  logic [1:0]     char_q;
  logic [5:0]     addr_q;
  logic [15:0]    row_sel_q;
  logic [15:0]    col_q;
  logic           tick_q;
  logic [DwW-1:0] dwell_q;
  logic [BlW-1:0] blank_q;

  logic [3:0]     row_d;
  logic [FcW-1:0] frame_d;
  logic [1:0]     char_d;
  logic           frame_wrap;
  logic           frame_last;
  logic           dwell_last;
  logic           blank_last;

  // Values applied at the end-of-BLANK advance edge.
  always_comb begin
    row_d      = row_q + 4'd1;
    frame_wrap = (row_q == 4'd15);
    frame_last = (frame_q == FcW'(FRAMES_PER_CHAR - 1));
    dwell_last = (dwell_q == DwW'(ROW_DWELL - 1));
    blank_last = (blank_q == BlW'(BLANK_CYCLES - 1));
    frame_d    = frame_q;
    char_d     = char_q;
    if (frame_wrap) begin
      frame_d = frame_last ? '0 : frame_q + FcW'(1);
      if (frame_last && !bus.i_hold) begin
        char_d = (char_q == 2'(NUM_CHARS - 1)) ? 2'd0 : char_q + 2'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      row_q     <= '0;
      frame_q   <= '0;
      char_q    <= '0;
      addr_q    <= '0;
      row_sel_q <= '0;
      col_q     <= '0;
      tick_q    <= 1'b0;
      dwell_q   <= '0;
      blank_q   <= '0;
    end else if (!bus.i_en) begin
      // Position in the scan (row, frame, glyph) survives a pause.
      state_q   <= StIdle;
      row_sel_q <= '0;
      col_q     <= '0;
      tick_q    <= 1'b0;
      dwell_q   <= '0;
      blank_q   <= '0;
    end else begin
      tick_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          state_q <= StFetch;
          addr_q  <= {char_q, row_q};
        end
        StFetch: begin
          state_q <= StLatch;
        end
        StLatch: begin
          // ROM address is still held, so the row word is captured straight into the column drive.
          state_q   <= StShow;
          row_sel_q <= 16'd1 << row_q;
          col_q     <= bus.i_rom_row;
          dwell_q   <= '0;
        end
        StShow: begin
          if (dwell_last) begin
            state_q   <= StBlank;
            row_sel_q <= '0;
            col_q     <= '0;
            blank_q   <= '0;
          end else begin
            dwell_q <= dwell_q + DwW'(1);
          end
        end
        StBlank: begin
          if (blank_last) begin
            state_q <= StFetch;
            row_q   <= row_d;
            frame_q <= frame_d;
            char_q  <= char_d;
            addr_q  <= {char_d, row_d};
            tick_q  <= frame_wrap;
          end else begin
            blank_q <= blank_q + BlW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.o_rom_addr   = addr_q;
  assign bus.o_row_sel    = row_sel_q;
  assign bus.o_col        = col_q;
  assign bus.o_char_idx   = char_q;
  assign bus.o_frame_tick = tick_q;

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Bench for dot_matrix_scanner: a phase-counter reference model pushes expected outputs each
// clock; every scenario task pops and compares them and adds its own fixed-value checks.
module tb_dot_matrix_scanner;

  localparam int unsigned RowDwell      = 4;
  localparam int unsigned BlankCycles   = 2;
  localparam int unsigned FramesPerChar = 2;
  localparam int unsigned NumChars      = 4;
  localparam int          Period        = 2 + RowDwell + BlankCycles;

  typedef struct packed {
    logic [5:0]  addr;
    logic [15:0] row_sel;
    logic [15:0] col;
    logic [1:0]  chr;
    logic        tick;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dot_matrix_scanner_if bus ();

  dot_matrix_scanner #(
    .ROW_DWELL       (RowDwell),
    .BLANK_CYCLES    (BlankCycles),
    .FRAMES_PER_CHAR (FramesPerChar),
    .NUM_CHARS       (NumChars)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [5:0] a);
    case (a)
      6'd0:    return 16'h0040;
      6'd6:    return 16'hF10E;
      6'd16:   return 16'h1040;
      6'd62:   return 16'hFFFE;
      6'd63:   return 16'h0000;
      default: return {a, 4'h5, a};
    endcase
  endfunction

  always_comb bus.i_rom_row = rom(bus.o_rom_addr);

  // Reference model state: phase within the row period, -1 when idle.
  int         m_phase = -1;
  logic [3:0] m_row   = '0;
  logic [1:0] m_char  = '0;
  int         m_frame = 0;
  logic [5:0] m_addr  = '0;
  logic       m_tick  = 1'b0;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  obs_t exp_q[$];
  obs_t exp_v;

  function automatic obs_t dut_obs();
    return obs_t'({bus.o_rom_addr, bus.o_row_sel, bus.o_col, bus.o_char_idx, bus.o_frame_tick});
  endfunction

  task automatic step();
    obs_t e;
    logic show;
    @(posedge clk);
    if (rst) begin
      m_phase = -1; m_row = '0; m_char = '0; m_frame = 0; m_addr = '0; m_tick = 1'b0;
    end else if (!bus.i_en) begin
      m_phase = -1; m_tick = 1'b0;
    end else if (m_phase == -1) begin
      m_phase = 0; m_addr = {m_char, m_row}; m_tick = 1'b0;
    end else if (m_phase == Period - 1) begin
      m_tick = (m_row == 4'd15);
      m_row  = m_row + 4'd1;
      if (m_tick) begin
        m_frame++;
        if (m_frame == int'(FramesPerChar)) begin
          m_frame = 0;
          if (!bus.i_hold) m_char = (m_char == 2'(NumChars - 1)) ? 2'd0 : m_char + 2'd1;
        end
      end
      m_addr  = {m_char, m_row};
      m_phase = 0;
    end else begin
      m_phase++; m_tick = 1'b0;
    end
    show      = (m_phase >= 2) && (m_phase < 2 + int'(RowDwell));
    e.addr    = m_addr;
    e.row_sel = show ? (16'd1 << m_row) : 16'd0;
    e.col     = show ? rom(m_addr) : 16'd0;
    e.chr     = m_char;
    e.tick    = m_tick;
    exp_q.push_back(e);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      bus.i_en = (i != 0);
      step();
      exp_v = exp_q.pop_front(); n_chk++;
      if (dut_obs() !== exp_v) begin
        n_fail++; $display("FAIL reset_model cyc=%0d got=%h want=%h", cyc, dut_obs(), exp_v);
      end
      n_chk++;
      if (dut_obs() !== obs_t'(0)) begin
        n_fail++; $display("FAIL reset_zero got=%h want=0", dut_obs());
      end
    end
  endtask

  task automatic test_first_row();
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      exp_v = exp_q.pop_front(); n_chk++;
      if (dut_obs() !== exp_v) begin
        n_fail++; $display("FAIL row0_model cyc=%0d got=%h want=%h", cyc, dut_obs(), exp_v);
      end
      if (i == 0) begin
        n_chk++;
        if (bus.o_rom_addr !== 6'd0 || bus.o_row_sel !== 16'd0) begin
          n_fail++; $display("FAIL row0_fetch addr=%0d sel=%h want addr 0 dark", bus.o_rom_addr,
                             bus.o_row_sel);
        end
      end else if (i >= 2 && i <= 5) begin
        n_chk++;
        if (bus.o_row_sel !== 16'h0001 || bus.o_col !== 16'h0040) begin
          n_fail++; $display("FAIL row0_show sel=%h col=%h want 0001/0040", bus.o_row_sel,
                             bus.o_col);
        end
      end else if (i >= 6) begin
        n_chk++;
        if (bus.o_row_sel !== 16'd0 || bus.o_col !== 16'd0) begin
          n_fail++; $display("FAIL row0_blank sel=%h col=%h want dark", bus.o_row_sel, bus.o_col);
        end
      end
    end
  endtask

  task automatic test_row6();
    for (int i = 0; i < 49; i++) begin
      step();
      exp_v = exp_q.pop_front(); n_chk++;
      if (dut_obs() !== exp_v) begin
        n_fail++; $display("FAIL row6_model cyc=%0d got=%h want=%h", cyc, dut_obs(), exp_v);
      end
      if (i == 40 || i == 47) begin
        n_chk++;
        if (bus.o_rom_addr !== 6'd6 || bus.o_row_sel !== 16'd0) begin
          n_fail++; $display("FAIL row6_addr i=%0d addr=%0d want 6", i, bus.o_rom_addr);
        end
      end else if (i >= 42 && i <= 45) begin
        n_chk++;
        if (bus.o_row_sel !== 16'h0040 || bus.o_col !== 16'hF10E) begin
          n_fail++; $display("FAIL row6_show sel=%h col=%h want 0040/F10E", bus.o_row_sel,
                             bus.o_col);
        end
      end else if (i == 48) begin
        n_chk++;
        if (bus.o_rom_addr !== 6'd7) begin
          n_fail++; $display("FAIL row6_period addr=%0d want 7", bus.o_rom_addr);
        end
      end
    end
  endtask

  task automatic test_frames();
    int tick_at[$];
    while (cyc < 262) begin
      step();
      exp_v = exp_q.pop_front(); n_chk++;
      if (dut_obs() !== exp_v) begin
        n_fail++; $display("FAIL frames_model cyc=%0d got=%h want=%h", cyc, dut_obs(), exp_v);
      end
      if (bus.o_frame_tick === 1'b1) tick_at.push_back(cyc);
      if (cyc == 257) begin
        n_chk++;
        if (bus.o_rom_addr !== 6'd16 || bus.o_char_idx !== 2'd1) begin
          n_fail++; $display("FAIL glyph1_fetch addr=%0d chr=%0d want 16/1", bus.o_rom_addr,
                             bus.o_char_idx);
        end
      end
      if (cyc == 259) begin
        n_chk++;
        if (bus.o_row_sel !== 16'h0001 || bus.o_col !== 16'h1040) begin
          n_fail++; $display("FAIL glyph1_show sel=%h col=%h want 0001/1040", bus.o_row_sel,
                             bus.o_col);
        end
      end
    end
    n_chk++;
    if (tick_at.size() != 2 || tick_at[0] != 129 || tick_at[1] != 257) begin
      n_fail++; $display("FAIL frame_ticks count=%0d want ticks at 129,257", tick_at.size());
    end
  endtask

  task automatic test_glyph3_wrap();
    while (cyc < 1025) begin
      step();
      exp_v = exp_q.pop_front(); n_chk++;
      if (dut_obs() !== exp_v) begin
        n_fail++; $display("FAIL g3_model cyc=%0d got=%h want=%h", cyc, dut_obs(), exp_v);
      end
      if (cyc == 881 || cyc == 889) begin
        n_chk++;
        if (bus.o_rom_addr !== ((cyc == 881) ? 6'd62 : 6'd63)) begin
          n_fail++; $display("FAIL g3_addr cyc=%0d addr=%0d want 62/63", cyc, bus.o_rom_addr);
        end
      end
      if (cyc >= 883 && cyc <= 886) begin
        n_chk++;
        if (bus.o_row_sel !== 16'h4000 || bus.o_col !== 16'hFFFE) begin
          n_fail++; $display("FAIL g3_row14 sel=%h col=%h want 4000/FFFE", bus.o_row_sel,
                             bus.o_col);
        end
      end
      if (cyc >= 891 && cyc <= 894) begin
        n_chk++;
        if (bus.o_row_sel !== 16'h8000 || bus.o_col !== 16'h0000) begin
          n_fail++; $display("FAIL g3_row15 sel=%h col=%h want 8000/0000", bus.o_row_sel,
                             bus.o_col);
        end
      end
    end
    n_chk++;
    if (bus.o_rom_addr !== 6'd0 || bus.o_char_idx !== 2'd0 || bus.o_frame_tick !== 1'b1) begin
      n_fail++; $display("FAIL glyph_wrap addr=%0d chr=%0d tick=%b want 0/0/1", bus.o_rom_addr,
                         bus.o_char_idx, bus.o_frame_tick);
    end
  endtask

  task automatic test_hold();
    int ticks = 0;
    bus.i_hold = 1'b1;
    while (cyc < 1283) begin
      step();
      exp_v = exp_q.pop_front(); n_chk++;
      if (dut_obs() !== exp_v) begin
        n_fail++; $display("FAIL hold_model cyc=%0d got=%h want=%h", cyc, dut_obs(), exp_v);
      end
      if (bus.o_frame_tick === 1'b1) ticks++;
      if (cyc == 1281) begin
        n_chk++;
        if (bus.o_char_idx !== 2'd0 || bus.o_frame_tick !== 1'b1 || bus.o_rom_addr !== 6'd0) begin
          n_fail++; $display("FAIL hold_boundary chr=%0d tick=%b addr=%0d want 0/1/0",
                             bus.o_char_idx, bus.o_frame_tick, bus.o_rom_addr);
        end
      end
    end
    n_chk++;
    if (ticks != 2 || bus.o_col !== 16'h0040) begin
      n_fail++; $display("FAIL hold_ticks ticks=%0d col=%h want 2/0040", ticks, bus.o_col);
    end
    bus.i_hold = 1'b0;
  endtask

  task automatic test_enable_reset();
    int shown = 0;
    while (cyc < 1324) begin
      step();
      exp_v = exp_q.pop_front(); n_chk++;
      if (dut_obs() !== exp_v) begin
        n_fail++; $display("FAIL en_model cyc=%0d got=%h want=%h", cyc, dut_obs(), exp_v);
      end
    end
    n_chk++;
    if (bus.o_row_sel !== 16'h0020) begin
      n_fail++; $display("FAIL en_midshow sel=%h want 0020", bus.o_row_sel);
    end
    bus.i_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_v = exp_q.pop_front(); n_chk++;
      if (dut_obs() !== exp_v) begin
        n_fail++; $display("FAIL dis_model cyc=%0d got=%h want=%h", cyc, dut_obs(), exp_v);
      end
      n_chk++;
      if (bus.o_row_sel !== 16'd0 || bus.o_col !== 16'd0 || bus.o_frame_tick !== 1'b0) begin
        n_fail++; $display("FAIL dis_dark sel=%h col=%h want dark", bus.o_row_sel, bus.o_col);
      end
    end
    bus.i_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_v = exp_q.pop_front(); n_chk++;
      if (dut_obs() !== exp_v) begin
        n_fail++; $display("FAIL reen_model cyc=%0d got=%h want=%h", cyc, dut_obs(), exp_v);
      end
      if (i == 0) begin
        n_chk++;
        if (bus.o_rom_addr !== 6'd5 || bus.o_row_sel !== 16'd0) begin
          n_fail++; $display("FAIL reen_fetch addr=%0d want 5", bus.o_rom_addr);
        end
      end
      if (bus.o_row_sel === 16'h0020) shown++;
    end
    n_chk++;
    if (shown != int'(RowDwell)) begin
      n_fail++; $display("FAIL reen_dwell shown=%0d want %0d", shown, RowDwell);
    end
    rst = 1'b1;
    step();
    exp_v = exp_q.pop_front(); n_chk++;
    if (dut_obs() !== obs_t'(0)) begin
      n_fail++; $display("FAIL midshow_reset got=%h want=0", dut_obs());
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_v = exp_q.pop_front(); n_chk++;
      if (dut_obs() !== exp_v) begin
        n_fail++; $display("FAIL postrst_model cyc=%0d got=%h want=%h", cyc, dut_obs(), exp_v);
      end
      if (i == 2) begin
        n_chk++;
        if (bus.o_row_sel !== 16'h0001 || bus.o_col !== 16'h0040) begin
          n_fail++; $display("FAIL postrst_show sel=%h col=%h want 0001/0040", bus.o_row_sel,
                             bus.o_col);
        end
      end
    end
  endtask

  initial begin
    bus.i_en   = 1'b0;
    bus.i_hold = 1'b0;
    rst        = 1'b1;
    test_reset();
    test_first_row();
    test_row6();
    test_frames();
    test_glyph3_wrap();
    test_hold();
    test_enable_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "bench time limit expired");
  end

endmodule
